// File: rtl/req_pkg.sv
// Types and defaults shared by the request transmitter and its receive-side peers.
// Default data width and burst limit are the values both ends must agree on.
package req_pkg;

  localparam int unsigned DefWidth  = 80;
  localparam int unsigned DefMaxLen = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } req_tx_state_e;

endpackage

// File: rtl/req_tx.sv
// Burst request transmitter: takes one (base, len) command and drives len consecutive
// words base, base+1, ... onto the req valid/ready interface, then pulses done_o.
module req_tx
  import req_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned MaxLen = DefMaxLen,
  localparam int unsigned LenW  = $clog2(MaxLen + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [Width-1:0] cmd_base_i,
  input  logic [LenW-1:0]  cmd_len_i,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [Width-1:0] req_data_o,
  output logic             req_last_o,
  output logic             busy_o,
  output logic             done_o
);

  req_tx_state_e    state_q, state_d;
  logic [Width-1:0] base_q, base_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [LenW-1:0]  idx_q, idx_d;
  logic [LenW-1:0]  idx_inc;
  logic [LenW-1:0]  cmd_len_clamped;
  logic             req_valid_q, req_valid_d;
  logic [Width-1:0] req_data_q, req_data_d;
  logic             req_last_q, req_last_d;
  logic             done_q, done_d;

  assign cmd_len_clamped = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
  assign idx_inc         = idx_q + LenW'(1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    req_last_d  = req_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          base_d = cmd_base_i;
          len_d  = cmd_len_clamped;
          idx_d  = '0;
          if (cmd_len_clamped == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // First beat is loaded here so it is valid the cycle after acceptance.
            state_d     = ST_SEND;
            req_valid_d = 1'b1;
            req_data_d  = cmd_base_i;
            req_last_d  = (cmd_len_clamped == LenW'(1));
          end
        end
      end

      ST_SEND: begin
        // req_valid_q is always high here, so ready alone completes the handshake.
        if (req_ready_i) begin
          idx_d = idx_inc;
          if (req_last_q) begin
            state_d     = ST_DONE;
            req_valid_d = 1'b0;
            req_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            req_data_d = base_q + Width'(idx_inc);
            req_last_d = (idx_inc == len_q - LenW'(1));
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      req_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      req_last_q  <= req_last_d;
      done_q      <= done_d;
    end
  end

  // Gated with rst_i so the command port refuses work during the reset cycle itself.
  assign cmd_ready_o = (state_q == ST_IDLE) & ~rst_i;
  assign busy_o      = ((state_q == ST_SEND) | (state_q == ST_DONE)) & ~rst_i;

  assign req_valid_o = req_valid_q;
  assign req_data_o  = req_data_q;
  assign req_last_o  = req_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_req_tx.sv
// Randomised scoreboard bench for req_tx: commands expand into expected beat lists,
// a negedge monitor compares every cycle's outputs against that expectation.
module tb_req_tx;
  import req_pkg::*;

  localparam int unsigned Width  = DefWidth;
  localparam int unsigned MaxLen = DefMaxLen;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  logic             clk;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [Width-1:0] cmd_base_i;
  logic [LenW-1:0]  cmd_len_i;
  logic             req_valid_o;
  logic             req_ready_i;
  logic [Width-1:0] req_data_o;
  logic             req_last_o;
  logic             busy_o;
  logic             done_o;

  typedef struct {
    logic [Width-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  bit    model_busy;
  bit    done_exp;
  bit    prev_rst;
  int    n_checks;
  int    n_errors;
  int    hs_count;
  int    ready_mode;
  int    pat_idx;
  bit    pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  req_tx #(
    .Width (Width),
    .MaxLen(MaxLen)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_base_i (cmd_base_i),
    .cmd_len_i  (cmd_len_i),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .req_data_o (req_data_o),
    .req_last_o (req_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [Width-1:0] got,
                     input logic [Width-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Receiver ready: held high, random, or a fixed toggle pattern.
  initial begin
    req_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       req_ready_i = 1'($urandom_range(0, 1));
        2: begin
          req_ready_i = pat[pat_idx % 7];
          pat_idx++;
        end
        default: req_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor and reference model: inputs are stable at the falling edge, so what is seen
  // here is exactly what the next rising edge will act on.
  initial begin
    beat_t       b;
    bit          idle;
    bit          next_done;
    int unsigned n;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        chk("rst_cmd_ready", cmd_ready_o, 0);
        if (prev_rst) begin
          chk("rst_valid", req_valid_o, 0);
          chk("rst_last", req_last_o, 0);
          chk("rst_done", done_o, 0);
          chk("rst_busy", busy_o, 0);
          chk("rst_data", req_data_o, 0);
        end
        exp_q.delete();
        model_busy = 0;
        done_exp   = 0;
        prev_rst   = 1;
      end else begin
        if (prev_rst) begin
          chk("post_rst_valid", req_valid_o, 0);
          chk("post_rst_last", req_last_o, 0);
          chk("post_rst_data", req_data_o, 0);
        end
        prev_rst = 0;
        chk("cmd_ready", cmd_ready_o, {{(Width-1){1'b0}}, !model_busy});
        chk("busy", busy_o, {{(Width-1){1'b0}}, model_busy});
        chk("done", done_o, {{(Width-1){1'b0}}, done_exp});
        chk("valid", req_valid_o, {{(Width-1){1'b0}}, exp_q.size() != 0});

        idle      = !model_busy;
        next_done = 0;
        if (done_exp) model_busy = 0;

        if (req_valid_o && exp_q.size() != 0) begin
          chk("data", req_data_o, exp_q[0].data);
          chk("last", req_last_o, {{(Width-1){1'b0}}, exp_q[0].last});
          if (req_ready_i) begin
            b = exp_q.pop_front();
            hs_count++;
            if (b.last) next_done = 1;
          end
        end

        if (cmd_valid_i && idle) begin
          model_busy = 1;
          n = (cmd_len_i > MaxLen) ? MaxLen : int'(cmd_len_i);
          if (n == 0) next_done = 1;
          for (int unsigned i = 0; i < n; i++) begin
            b.data = cmd_base_i + Width'(i);
            b.last = (i == n - 1);
            exp_q.push_back(b);
          end
        end
        done_exp = next_done;
      end
    end
  end

  task automatic issue(input logic [Width-1:0] base, input int len);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_base_i  = base;
    cmd_len_i   = LenW'(len);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept_timeout: got no cmd_ready, expected one within 500 cycles");
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!model_busy && exp_q.size() == 0 && !done_exp) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got model still busy, expected idle within 1000 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0]      r;
    logic [Width-1:0] all_ones;
    int               start;
    bit               ok;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_base_i  = '0;
    cmd_len_i   = '0;
    ready_mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    issue(80'h10, 4);
    wait_idle();

    ready_mode = 2;
    pat_idx    = 0;
    issue(80'h10, 4);
    wait_idle();
    ready_mode = 0;

    all_ones = '1;
    issue(all_ones - 80'd1, 3);
    wait_idle();

    issue(80'h0, 0);
    issue(80'h55, 1);
    wait_idle();

    // Reset after the second beat of an eight-beat burst.
    start = hs_count;
    issue(80'h100, 8);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (hs_count >= start + 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL mid_burst_beats: got %0d beats, expected 2", hs_count - start);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    issue(80'h200, 1);
    wait_idle();

    // New command values offered while the burst is still sending.
    issue(80'h300, 8);
    repeat (4) begin
      r           = {$urandom(), $urandom(), $urandom()};
      cmd_valid_i = 1'b1;
      cmd_base_i  = r[Width-1:0];
      cmd_len_i   = LenW'($urandom_range(0, 20));
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 1'b0;
    wait_idle();

    issue(80'h400, 25);
    wait_idle();

    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      r = {$urandom(), $urandom(), $urandom()};
      if (k % 8 == 3) r[Width-1:8] = '1;
      issue(r[Width-1:0], int'($urandom_range(0, 20)));
    end
    wait_idle();
    ready_mode = 0;
    repeat (3) @(posedge clk);

    chk("final_queue_empty", Width'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
